ysyx_22040750_clint: RTL
========================

YSYX_22040750_CLINT -- requirements
Module: ysyx_22040750_clint

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0200_0000, CLINT window base (64 KiB window).
REQ-002 SHALL have parameter TICK_DIV, default 1, sys-clock cycles per mtime increment (legal 1..65535).
REQ-003 SHALL have port I_sys_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port I_rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port I_req_valid  input  1  MMIO request valid.
REQ-006 SHALL have port O_req_ready  output  1  block can accept a request.
REQ-007 SHALL have port I_req_wen  input  1  1 = write, 0 = read.
REQ-008 SHALL have port I_req_addr  input  32  byte address; bits [2:0] ignored (64-bit aligned access).
REQ-009 SHALL have port I_req_wdata  input  64  write data.
REQ-010 SHALL have port I_req_wmask  input  8  byte enables for writes.
REQ-011 SHALL have port O_resp_valid  output  1  response valid.
REQ-012 SHALL have port I_resp_ready  input  1  consumer accepts response.
REQ-013 SHALL have port O_resp_rdata  output  64  read data (0 for writes).
REQ-014 SHALL have port O_resp_err  output  1  address outside defined registers.
REQ-015 SHALL have port O_mtip  output  1  machine timer interrupt pending, to trap/CSR logic.
REQ-016 SHALL have port O_msip  output  1  machine software interrupt pending, to trap/CSR logic.
REQ-017 SHALL have port O_mtime  output  64  current mtime value.

Function
REQ-018 SHALL decode offsets from BASE_ADDR: MSIP 0x0000 (bit0 only, other bits read 0), MTIMECMP 0x4000, MTIME 0xBFF8; any other address in or out of window is a miss.
REQ-019 SHALL implement two-state FSM: IDLE (O_req_ready=1, O_resp_valid=0) and RESP (O_req_ready=0, O_resp_valid=1).
REQ-020 SHALL accept a request on I_req_valid & O_req_ready, move IDLE->RESP next cycle, and stay in RESP until I_resp_ready, then return to IDLE (no back-to-back accept; throughput one request per two cycles minimum).
REQ-021 SHALL capture read data at acceptance cycle (pre-increment mtime value) and hold O_resp_rdata/O_resp_err stable throughout RESP.
REQ-022 SHALL apply writes at acceptance edge, byte-merged per I_req_wmask; miss writes are dropped with O_resp_err=1 and rdata=0.
REQ-023 SHALL increment mtime by 1 on the cycle the prescaler reaches TICK_DIV-1, prescaler then returning to 0; TICK_DIV=1 increments every cycle.
REQ-024 SHALL wrap mtime from 64'hFFFF_FFFF_FFFF_FFFF to 0 without flag.
REQ-025 SHALL give an accepted MTIME write priority over that cycle's increment, and reset the prescaler to 0 on any MTIME write.
REQ-026 SHALL drive O_mtip = (mtime >= mtimecmp), unsigned 64-bit, combinational from registers (visible the cycle after the causing write or tick).
REQ-027 SHALL drive O_msip = msip register bit0.
REQ-028 SHALL hold O_mtip asserted until mtimecmp is raised above mtime or mtime is written below mtimecmp (level, no latching).

Reset
REQ-029 SHALL on I_rst set mtime=0, prescaler=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, msip=0, FSM=IDLE, O_resp_rdata=0, O_resp_err=0; hence O_mtip=0, O_msip=0, O_resp_valid=0, O_req_ready=1 after reset.
REQ-030 SHALL on reset during RESP drop the pending response without handshake; a request presented during the reset cycle is not accepted.

Structure
REQ-031 SHALL place register offsets (MSIP, MTIMECMP, MTIME), default BASE_ADDR and FSM state encodings in the shared ysyx_22040750 package.
REQ-032 SHALL implement prescaler plus mtime counter as sub-module ysyx_22040750_clint_timer (inputs: tick divisor, write enable, write data, mask; output: mtime).

Verification
REQ-033 Reset, idle 10 cycles, TICK_DIV=1 -> O_mtime=10, O_mtip=0, O_msip=0, O_req_ready=1.
REQ-034 Write MTIMECMP=20 (wmask 8'hFF) after reset -> O_mtip rises the cycle mtime reaches 20; write MTIMECMP=100 -> O_mtip falls next cycle.
REQ-035 Write MTIME=64'hFFFF_FFFF_FFFF_FFFE -> two ticks later O_mtime=0; write coinciding with tick leaves exact written value.
REQ-036 Write MSIP wdata=1 then read MSIP -> O_msip=1, rdata=1; write wmask=8'h00 -> no change; read offset 0x1000 -> O_resp_err=1, rdata=0.
REQ-037 Read MTIME with I_resp_ready held low 5 cycles -> O_resp_valid held, rdata unchanged, O_req_ready=0; I_rst asserted in RESP -> O_resp_valid=0 next cycle.
REQ-038 TICK_DIV=4, 40 cycles after reset -> O_mtime=10.

Source files
------------

// File: rtl/ysyx_22040750_clint_pkg.sv
// +--------------------------------------------------------------------+
// | ysyx_22040750_clint_pkg                                            |
// | Shared CLINT register offsets, reset values, FSM states, helpers.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

package ysyx_22040750_clint_pkg;

  localparam logic [31:0] c_base_addr_dflt = 32'h0200_0000;

  localparam logic [15:0] c_off_msip     = 16'h0000;
  localparam logic [15:0] c_off_mtimecmp = 16'h4000;
  localparam logic [15:0] c_off_mtime    = 16'hBFF8;

  localparam logic [63:0] c_mtimecmp_rst = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } clint_state_e;

  function automatic logic [63:0] merge_bytes(
    input logic [63:0] i_old,
    input logic [63:0] i_new,
    input logic [7:0]  i_mask
  );
    logic [63:0] v;
    v = i_old;
    for (int b = 0; b < 8; b++) begin
      if (i_mask[b]) v[8*b +: 8] = i_new[8*b +: 8];
    end
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx_22040750_clint_timer.sv
// +--------------------------------------------------------------------+
// | ysyx_22040750_clint_timer                                          |
// | Prescaler plus 64-bit mtime counter with byte-masked overwrite.    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module ysyx_22040750_clint_timer
  import ysyx_22040750_clint_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_tick_div,
  input  logic        i_wen,
  input  logic [63:0] i_wdata,
  input  logic [7:0]  i_wmask,
  output logic [63:0] o_mtime
);

  logic [15:0] r_presc;
  logic [63:0] r_mtime;
  logic        w_tick;

  // ">=" keeps the prescaler from running away if the divisor shrinks.
  assign w_tick  = (r_presc >= (i_tick_div - 16'd1));
  assign o_mtime = r_mtime;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_presc <= '0;
      r_mtime <= '0;
    end else if (i_wen) begin
      r_presc <= '0;
      r_mtime <= merge_bytes(r_mtime, i_wdata, i_wmask);
    end else if (w_tick) begin
      r_presc <= '0;
      r_mtime <= r_mtime + 64'd1;
    end else begin
      r_presc <= r_presc + 16'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ysyx_22040750_clint.sv
// +--------------------------------------------------------------------+
// | ysyx_22040750_clint                                                |
// | MMIO core-local interruptor: msip, mtimecmp, mtime, mtip/msip.     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module ysyx_22040750_clint
  import ysyx_22040750_clint_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = c_base_addr_dflt,
  parameter int unsigned TICK_DIV  = 1
) (
  input  logic        I_sys_clk,
  input  logic        I_rst,
  input  logic        I_req_valid,
  output logic        O_req_ready,
  input  logic        I_req_wen,
  input  logic [31:0] I_req_addr,
  input  logic [63:0] I_req_wdata,
  input  logic [7:0]  I_req_wmask,
  output logic        O_resp_valid,
  input  logic        I_resp_ready,
  output logic [63:0] O_resp_rdata,
  output logic        O_resp_err,
  output logic        O_mtip,
  output logic        O_msip,
  output logic [63:0] O_mtime
);

  localparam logic [15:0] c_tick_div = 16'(TICK_DIV);

  clint_state_e r_state;
  clint_state_e w_state_nxt;

  logic        r_msip;
  logic [63:0] r_mtimecmp;
  logic [63:0] r_rdata;
  logic        r_err;
  logic [63:0] w_mtime;

  logic        w_accept;
  logic        w_in_win;
  logic [15:0] w_off;
  logic        w_hit_msip;
  logic        w_hit_cmp;
  logic        w_hit_mtime;
  logic        w_miss;
  logic [63:0] w_rdata;
  logic        w_unused_addr_lsb;

  assign w_unused_addr_lsb = ^I_req_addr[2:0];

  // The window is assumed 64 KiB aligned, so only the upper half is compared.
  assign w_in_win    = (I_req_addr[31:16] == BASE_ADDR[31:16]);
  assign w_off       = {I_req_addr[15:3], 3'b000};
  assign w_hit_msip  = w_in_win && (w_off == c_off_msip);
  assign w_hit_cmp   = w_in_win && (w_off == c_off_mtimecmp);
  assign w_hit_mtime = w_in_win && (w_off == c_off_mtime);
  assign w_miss      = ~(w_hit_msip | w_hit_cmp | w_hit_mtime);

  assign O_req_ready  = (r_state == ST_IDLE);
  assign O_resp_valid = (r_state == ST_RESP);
  assign w_accept     = I_req_valid & O_req_ready & ~I_rst;

  always_ff @(posedge I_sys_clk) begin
    if (I_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)     w_state_nxt = ST_RESP;
      ST_RESP: if (I_resp_ready) w_state_nxt = ST_IDLE;
      default:                   w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_rdata = '0;
    if (!I_req_wen) begin
      if (w_hit_msip)  w_rdata = {63'd0, r_msip};
      if (w_hit_cmp)   w_rdata = r_mtimecmp;
      if (w_hit_mtime) w_rdata = w_mtime;
    end
  end

  always_ff @(posedge I_sys_clk) begin
    if (I_rst) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_rdata <= w_rdata;
      r_err   <= w_miss;
    end
  end

  always_ff @(posedge I_sys_clk) begin
    if (I_rst) begin
      r_msip     <= 1'b0;
      r_mtimecmp <= c_mtimecmp_rst;
    end else if (w_accept && I_req_wen) begin
      if (w_hit_msip && I_req_wmask[0]) r_msip <= I_req_wdata[0];
      if (w_hit_cmp) r_mtimecmp <= merge_bytes(r_mtimecmp, I_req_wdata, I_req_wmask);
    end
  end

  ysyx_22040750_clint_timer u_timer (
    .i_clk      (I_sys_clk),
    .i_rst      (I_rst),
    .i_tick_div (c_tick_div),
    .i_wen      (w_accept & I_req_wen & w_hit_mtime),
    .i_wdata    (I_req_wdata),
    .i_wmask    (I_req_wmask),
    .o_mtime    (w_mtime)
  );

  assign O_resp_rdata = r_rdata;
  assign O_resp_err   = r_err;
  assign O_mtime      = w_mtime;
  assign O_msip       = r_msip;
  assign O_mtip       = (w_mtime >= r_mtimecmp);

endmodule

`default_nettype wire
